// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Optional parity support is selected with the RX_PARITY_EN macro.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Phase indices of the three majority samples, centred on the bit.
    function automatic int maj_lo(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int maj_mid(input int oversample);
        return oversample / 2;
    endfunction

    // The last sample doubles as the decision point for the bit.
    function automatic int maj_hi(input int oversample);
        return oversample / 2 + 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, tick prescaler, bit-phase counter
// and 3-sample majority vote. The counters re-align to a start edge when
// the frame FSM asserts align_i.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic align_i,
    output logic din_sync_o,
    output logic fall_o,
    output logic bit_stb_o,
    output logic bit_val_o
);

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int FW = $clog2(OVERSAMPLE);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
    localparam logic [FW-1:0] PHASE_LAST = FW'(OVERSAMPLE - 1);
    localparam logic [FW-1:0] PH_LO      = FW'(maj_lo(OVERSAMPLE));
    localparam logic [FW-1:0] PH_MID     = FW'(maj_mid(OVERSAMPLE));
    localparam logic [FW-1:0] PH_HI      = FW'(maj_hi(OVERSAMPLE));

    logic          meta_q, sync_q, prev_q;
    logic [PW-1:0] presc_q;
    logic [FW-1:0] phase_q;
    logic          smp_lo_q, smp_mid_q;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    // Synchronise the asynchronous line and keep one cycle of history for edges.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Prescaler and bit-phase counter, both restarted on an accepted start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            phase_q <= '0;
        end else if (align_i) begin
            presc_q <= '0;
            phase_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Capture the first two majority samples; the third is taken live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
        end else if (tick) begin
            if (phase_q == PH_LO)  smp_lo_q  <= sync_q;
            if (phase_q == PH_MID) smp_mid_q <= sync_q;
        end
    end

    assign din_sync_o = sync_q;
    assign fall_o     = prev_q & ~sync_q;
    assign bit_stb_o  = tick && (phase_q == PH_HI) && !align_i;
    assign bit_val_o  = maj3(smp_lo_q, smp_mid_q, sync_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start/data/stop framing on top of the
// majority-voting sampler, single holding register with valid/ready,
// framing-error and overrun pulses. Defining RX_PARITY_EN adds a parity
// bit after the data and the PARITY_ODD parameter.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 27,
    parameter int STOP_BITS     = 1
`ifdef RX_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_parity_err
);

    localparam int            BW        = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic din_sync, fall, bit_stb, bit_val, align;

    rx_state_e         state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              stop_cnt_q;
    logic              done_q;
    logic              ferr_q;
`ifdef RX_PARITY_EN
    logic              par_bad_q;
    logic              perr_q;
`endif

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ovr_q;

    // Only an edge seen while idle starts a frame and re-aligns the bit phase.
    assign align = (state_q == ST_IDLE) && fall;

    uart_rx_sampler #(
        .OVERSAMPLE    (OVERSAMPLE),
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .align_i    (align),
        .din_sync_o (din_sync),
        .fall_o     (fall),
        .bit_stb_o  (bit_stb),
        .bit_val_o  (bit_val)
    );

    // Frame FSM: walks start, data, optional parity and stop bits on decision strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle so each fires for
            // exactly one clock without extra clear logic.
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q    <= ST_START;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
`ifdef RX_PARITY_EN
                        par_bad_q  <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    // A start bit that votes high was a glitch: drop it silently.
                    if (bit_stb) state_q <= bit_val ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (bit_stb) begin
                        shreg_q <= {bit_val, shreg_q[DATA_W-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
`ifdef RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_stb) begin
                        if (bit_val != ((^shreg_q) ^ PARITY_ODD)) begin
                            perr_q    <= 1'b1;
                            par_bad_q <= 1'b1;
                        end
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_stb) begin
                        if (!bit_val) begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end else if (stop_cnt_q == STOP_LAST) begin
                            // Back to idle at once so a start edge in the
                            // second half of the stop bit is honoured.
                            state_q <= ST_IDLE;
`ifdef RX_PARITY_EN
                            done_q  <= !par_bad_q;
`else
                            done_q  <= 1'b1;
`endif
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (din_sync) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Holding register: load on completion, overrun if the old word is still unread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: table of frames, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_param;

    localparam int DW  = 8;
    localparam int OS  = 16;
    localparam int CPT = 4;
    localparam int SB  = 1;
    localparam int BIT = OS * CPT;
`ifdef RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    // rx_valid must rise a little after the middle of the last stop bit.
    localparam int LAT_LO = (1 + DW + PB + SB - 1) * BIT + BIT / 2;
    localparam int LAT_HI = LAT_LO + 4 * CPT + 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          stop_ok;
        logic          par_bad;
        int            spike_bit;
        int            spike_off;
        int            hold_low;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_frame_err, rx_overrun, rx_parity_err;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_W        (DW),
        .OVERSAMPLE    (OS),
        .CLKS_PER_TICK (CPT),
        .STOP_BITS     (SB)
`ifdef RX_PARITY_EN
        ,
        .PARITY_ODD    (1'b0)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_parity_err (rx_parity_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Output monitor: pulse counters, rx_valid rise time, consumer-side word log.
    int            cyc = 0;
    int            ferr_n = 0, ovr_n = 0, perr_n = 0, rise_cyc = -1;
    logic          valid_prev = 1'b0;
    logic [DW-1:0] got_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_frame_err) ferr_n++;
            if (rx_overrun) ovr_n++;
            if (rx_parity_err) perr_n++;
            if (rx_valid && !valid_prev) rise_cyc = cyc;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
        valid_prev = rx_valid;
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drive one frame on the line, optionally with a 1-clk inverted spike in a data bit.
    task automatic send_frame(input vec_t v, output int start_cyc);
        logic b;
        start_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < DW; i++) begin
            b = v.data[i];
            if (i == v.spike_bit) begin
                hold(b, v.spike_off);
                hold(~b, 1);
                hold(b, BIT - v.spike_off - 1);
            end else begin
                hold(b, BIT);
            end
        end
`ifdef RX_PARITY_EN
        hold((^v.data) ^ v.par_bad, BIT);
`endif
        for (int s = 0; s < SB; s++) hold(v.stop_ok, BIT);
    endtask

    // Frame-level reference: a good frame yields exactly its data word once,
    // a bad stop bit yields one framing pulse, a bad parity one parity pulse.
    task automatic run_frame(input vec_t v, input string tag);
        int   f0, o0, p0, st;
        logic exp_ok;
        f0 = ferr_n; o0 = ovr_n; p0 = perr_n;
        got_q.delete();
        send_frame(v, st);
        if (v.hold_low > 0) hold(1'b0, v.hold_low);
        hold(1'b1, 2 * BIT);
        exp_ok = v.stop_ok && !v.par_bad;
        check({tag, " words"}, got_q.size(), exp_ok ? 1 : 0);
        if (exp_ok) begin
            check({tag, " data"}, got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'(v.data));
            check_range({tag, " latency"}, rise_cyc - st, LAT_LO, LAT_HI);
        end
        check({tag, " frame_err"}, ferr_n - f0, v.stop_ok ? 0 : 1);
        check({tag, " overrun"}, ovr_n - o0, 0);
`ifdef RX_PARITY_EN
        check({tag, " parity_err"}, perr_n - p0, v.par_bad ? 1 : 0);
`else
        check({tag, " parity_err"}, perr_n - p0, 0);
`endif
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        int f0, o0, st;

        vecs.push_back('{8'hA5, 1'b1, 1'b0, -1, 0, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 3, 32, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, -1, 0, 200});
        vecs.push_back('{8'h81, 1'b1, 1'b0, -1, 0, 0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 0, 34, 0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 7, 38, 0});
`ifdef RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, -1, 0, 0});
        vecs.push_back('{8'h07, 1'b1, 1'b1, -1, 0, 0});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset frame_err", rx_frame_err, 0);
        check("reset overrun", rx_overrun, 0);
        check("reset parity_err", rx_parity_err, 0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // Table-driven frames.
        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Short low glitch on an idle line must be ignored.
        f0 = ferr_n;
        got_q.delete();
        hold(1'b0, 20);
        hold(1'b1, 2 * BIT);
        check("glitch words", got_q.size(), 0);
        check("glitch valid", rx_valid, 0);
        check("glitch frame_err", ferr_n - f0, 0);
        run_frame('{8'h5A, 1'b1, 1'b0, -1, 0, 0}, "after_glitch");

        // Overrun: two frames with the consumer stalled.
        rx_ready = 1'b0;
        o0 = ovr_n;
        got_q.delete();
        v = '{8'h11, 1'b1, 1'b0, -1, 0, 0};
        send_frame(v, st);
        hold(1'b1, BIT);
        v = '{8'h22, 1'b1, 1'b0, -1, 0, 0};
        send_frame(v, st);
        hold(1'b1, BIT);
        check("ovr valid held", rx_valid, 1);
        check("ovr data held", rx_data, 8'h11);
        check("ovr pulses", ovr_n - o0, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr valid drop", rx_valid, 0);
        check("ovr handshake words", got_q.size(), 1);
        check("ovr handshake data", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h11);
        @(posedge clk);
        #2;

        // Asynchronous reset in the middle of a frame.
        hold(1'b0, 3 * BIT);
        rst_n = 1'b0;
        #1;
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_data", rx_data, 0);
        check("midreset pulses", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 10);
        run_frame('{8'hC3, 1'b1, 1'b0, -1, 0, 0}, "after_reset");

        // Randomized frames with occasional bad stop/parity and data-bit spikes.
        for (int n = 0; n < 20; n++) begin
            v.data      = DW'($urandom);
            v.stop_ok   = ($urandom_range(0, 7) != 0);
`ifdef RX_PARITY_EN
            v.par_bad   = ($urandom_range(0, 7) == 0);
`else
            v.par_bad   = 1'b0;
`endif
            v.spike_bit = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DW - 1)) : -1;
            v.spike_off = int'($urandom_range(0, BIT - 1));
            v.hold_low  = v.stop_ok ? 0 : int'($urandom_range(0, 100));
            run_frame(v, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
